// File: rtl/mac_dot_seq_if.sv
// Job, operand-memory and MAC-side signals of the dot-product sequencer.
// master is the sequencer's view; slave is the view of whatever surrounds it.
interface mac_dot_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 65
);
    logic              start;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              mem_a_en;
    logic              mem_b_en;
    logic [ADDR_W-1:0] mem_a_addr;
    logic [ADDR_W-1:0] mem_b_addr;
    logic [DATA_W-1:0] mem_a_rdata;
    logic [DATA_W-1:0] mem_b_rdata;
    logic              mac_clear;
    logic              mac_next;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_psum;

    modport master (
        input  start, base_a, base_b, len, mem_a_rdata, mem_b_rdata, mac_psum,
        output busy, done, result, result_valid, mem_a_en, mem_b_en,
               mem_a_addr, mem_b_addr, mac_clear, mac_next, mac_a, mac_b
    );

    modport slave (
        output start, base_a, base_b, len, mem_a_rdata, mem_b_rdata, mac_psum,
        input  busy, done, result, result_valid, mem_a_en, mem_b_en,
               mem_a_addr, mem_b_addr, mac_clear, mac_next, mac_a, mac_b
    );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs from two synchronous-read
// memories into a 2-stage pipelined MAC and captures the final psum.
//
// state   | meaning
// IDLE    | waiting for start, job parameters latched on acceptance
// CLEAR   | mac_clear pulse, zeroes the accumulator
// ISSUE   | one operand-memory read per element, address wraps
// DRAIN   | waiting for the last product to reach the accumulator
// CAPTURE | result <= mac_psum
// DONE    | done pulse, result_valid set
module mac_dot_seq #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 65,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mac_dot_seq_if.master dot_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              en_q, en_d;
    logic              clear_q, clear_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [MAC_LAT:0]  vld_q, vld_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        en_d     = 1'b0;
        clear_d  = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        rv_d     = rv_q;
        result_d = result_q;
        // bit 0 marks the rdata cycle, bit MAC_LAT the accumulate cycle
        vld_d    = {vld_q[MAC_LAT-1:0], en_q};

        unique case (state_q)
            S_IDLE: begin
                if (dot_if.start) begin
                    addr_a_d = dot_if.base_a;
                    addr_b_d = dot_if.base_b;
                    cnt_d    = dot_if.len;
                    rv_d     = 1'b0;
                    clear_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q != '0) begin
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_ISSUE: begin
                cnt_d    = cnt_q - CNT_ONE;
                addr_a_d = addr_a_q + ADDR_ONE;
                addr_b_d = addr_b_q + ADDR_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DRAIN;
                end else begin
                    en_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // leave once the final accumulate is the one happening now
                if (vld_d == '0) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = dot_if.mac_psum;
                done_d   = 1'b1;
                rv_d     = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            en_q     <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            result_q <= '0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            en_q     <= en_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rv_q     <= rv_d;
            result_q <= result_d;
            vld_q    <= vld_d;
        end
    end

    assign dot_if.busy         = busy_q;
    assign dot_if.done         = done_q;
    assign dot_if.result       = result_q;
    assign dot_if.result_valid = rv_q;
    assign dot_if.mem_a_en     = en_q;
    assign dot_if.mem_b_en     = en_q;
    assign dot_if.mem_a_addr   = addr_a_q;
    assign dot_if.mem_b_addr   = addr_b_q;
    assign dot_if.mac_clear    = clear_q;
    assign dot_if.mac_next     = vld_q[MAC_LAT];
    // stale rdata outside the valid cycle must not reach the MAC
    assign dot_if.mac_a        = vld_q[0] ? dot_if.mem_a_rdata : {DATA_W{1'b0}};
    assign dot_if.mac_b        = vld_q[0] ? dot_if.mem_b_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: behavioural MAC and memories around the DUT, a
// job-level timing/result model, and a per-cycle output compare.
module tb_mac_dot_seq;
    logic clk;
    logic rst;

    mac_dot_seq_if #(.ADDR_W(8), .DATA_W(32), .ACC_W(65)) bus ();

    mac_dot_seq #(.ADDR_W(8), .DATA_W(32), .ACC_W(65), .MAC_LAT(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .dot_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    // operand memories: rdata is junk when not enabled
    always @(posedge clk) begin
        bus.mem_a_rdata <= bus.mem_a_en ? mem_a[bus.mem_a_addr] : $urandom;
        bus.mem_b_rdata <= bus.mem_b_en ? mem_b[bus.mem_b_addr] : $urandom;
    end

    // 2-stage MAC: operand regs, product reg, accumulator
    logic [31:0] op_a, op_b;
    logic [63:0] prod;
    logic [64:0] acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0; op_b <= '0; prod <= '0; acc <= '0;
        end else begin
            op_a <= bus.mac_a;
            op_b <= bus.mac_b;
            prod <= 64'(op_a) * 64'(op_b);
            if (bus.mac_clear) acc <= '0;
            else if (bus.mac_next) acc <= acc + 65'(prod);
        end
    end
    assign bus.mac_psum = acc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dones = 0;
    int exp_dones = 0;

    // job model
    bit          job_active = 1'b0;
    int          job_t0, job_len, job_ba, job_bb, job_tdone;
    logic [64:0] job_res;
    logic [64:0] prev_res = '0;
    bit          prev_rv = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [64:0] dot_ref(input int ba, input int bb, input int len);
        logic [64:0] s;
        s = '0;
        for (int i = 0; i < len; i++)
            s = s + 65'(64'(mem_a[(ba + i) & 255]) * 64'(mem_b[(bb + i) & 255]));
        return s;
    endfunction

    // per-cycle compare against the job model
    initial begin
        int rel;
        bit act;
        logic [64:0] e_res;
        bit e_rv;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.done) dones++;
            rel = cyc - job_t0;
            act = job_active && rel >= 1;
            if (act && rel >= job_tdone) begin
                e_res = job_res; e_rv = 1'b1;
            end else if (act) begin
                e_res = prev_res; e_rv = 1'b0;
            end else begin
                e_res = prev_res; e_rv = prev_rv;
            end
            chk("busy", 128'(bus.busy), 128'(act && rel <= job_tdone));
            chk("done", 128'(bus.done), 128'(act && rel == job_tdone));
            chk("mac_clear", 128'(bus.mac_clear), 128'(act && rel == 1));
            chk("mac_next", 128'(bus.mac_next), 128'(act && rel >= 5 && rel <= job_len + 4));
            chk("mem_a_en", 128'(bus.mem_a_en), 128'(act && rel >= 2 && rel <= job_len + 1));
            chk("mem_b_en", 128'(bus.mem_b_en), 128'(act && rel >= 2 && rel <= job_len + 1));
            if (act && rel >= 2 && rel <= job_len + 1) begin
                chk("mem_a_addr", 128'(bus.mem_a_addr), 128'((job_ba + rel - 2) & 255));
                chk("mem_b_addr", 128'(bus.mem_b_addr), 128'((job_bb + rel - 2) & 255));
            end
            if (act && rel >= 3 && rel <= job_len + 2) begin
                chk("mac_a", 128'(bus.mac_a), 128'(mem_a[(job_ba + rel - 3) & 255]));
                chk("mac_b", 128'(bus.mac_b), 128'(mem_b[(job_bb + rel - 3) & 255]));
            end else begin
                chk("mac_a_gated", 128'(bus.mac_a), 128'(0));
                chk("mac_b_gated", 128'(bus.mac_b), 128'(0));
            end
            chk("result", 128'(bus.result), 128'(e_res));
            chk("result_valid", 128'(bus.result_valid), 128'(e_rv));
        end
    end

    task automatic reset_check();
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_result", 128'(bus.result), 128'(0));
        chk("rst_result_valid", 128'(bus.result_valid), 128'(0));
        chk("rst_mem_en", 128'({bus.mem_a_en, bus.mem_b_en}), 128'(0));
        chk("rst_mem_addr", 128'({bus.mem_a_addr, bus.mem_b_addr}), 128'(0));
        chk("rst_mac_ctl", 128'({bus.mac_clear, bus.mac_next}), 128'(0));
        chk("rst_mac_ops", 128'({bus.mac_a, bus.mac_b}), 128'(0));
    endtask

    // runs one job from a falling edge; returns on the falling edge of DONE
    task automatic run_job(input int ba, input int bb, input int len,
                           input logic [64:0] lit, input bit use_lit,
                           input int stray_rel, input int rst_rel, input bit b2b);
        while (job_active && cyc <= job_t0 + job_tdone) @(negedge clk);
        if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
        if (job_active) begin
            prev_res = job_res;
            prev_rv  = 1'b1;
        end
        job_res   = dot_ref(ba, bb, len);
        job_t0    = cyc;
        job_len   = len;
        job_ba    = ba;
        job_bb    = bb;
        job_tdone = (len == 0) ? 3 : len + 6;
        job_active = 1'b1;
        if (use_lit) chk("model_vs_literal", 128'(job_res), 128'(lit));
        bus.base_a = 8'(ba);
        bus.base_b = 8'(bb);
        bus.len    = 9'(len);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.base_a = 8'($urandom);
        bus.base_b = 8'($urandom);
        bus.len    = 9'($urandom);
        if (stray_rel > 0) begin
            while (cyc < job_t0 + stray_rel) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        if (rst_rel > 0) begin
            while (cyc < job_t0 + rst_rel) @(negedge clk);
            rst = 1'b1;
            job_active = 1'b0;
            prev_res = '0;
            prev_rv  = 1'b0;
            #1;
            reset_check();
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        while (cyc < job_t0 + job_tdone) @(negedge clk);
        exp_dones++;
        chk("done_at_expected_cycle", 128'(bus.done), 128'(1));
        if (use_lit) chk("result_literal", 128'(bus.result), 128'(lit));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, stray;
        rst = 1'b0;
        bus.start  = 1'b0;
        bus.base_a = '0;
        bus.base_b = '0;
        bus.len    = '0;
        bus.mem_a_rdata = '0;
        bus.mem_b_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        #1 rst = 1'b1;
        #2 reset_check();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4-element job with an ignored start mid-job, then back-to-back job
        for (int i = 0; i < 4; i++) begin
            mem_a[16 + i] = 32'(i + 1);
            mem_b[32 + i] = 32'(i + 5);
        end
        run_job(16, 32, 4, 65'd70, 1'b1, 4, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_a[48 + i] = 32'd2;
            mem_b[64 + i] = 32'd2;
        end
        run_job(48, 64, 3, 65'd12, 1'b1, 0, 0, 1'b1);

        // all-ones operands, no truncation
        mem_a[8'h40] = 32'hFFFF_FFFF;
        mem_b[8'h50] = 32'hFFFF_FFFF;
        run_job(8'h40, 8'h50, 1, 65'h0_FFFF_FFFE_0000_0001, 1'b1, 0, 0, 1'b0);

        // empty job
        run_job(8'h33, 8'h77, 0, 65'd0, 1'b1, 0, 0, 1'b0);

        // address wrap on A
        mem_a[8'hFE] = 32'd10; mem_a[8'hFF] = 32'd20;
        mem_a[8'h00] = 32'd30; mem_a[8'h01] = 32'd40;
        for (int i = 0; i < 4; i++) mem_b[8'h80 + i] = 32'(i + 1);
        run_job(8'hFE, 8'h80, 4, 65'd300, 1'b1, 0, 0, 1'b0);

        // reset mid-job, then a clean job
        run_job(8'h90, 8'hA0, 8, 65'd0, 1'b0, 0, 6, 1'b0);
        mem_a[8'hC0] = 32'd3; mem_a[8'hC1] = 32'd3;
        mem_b[8'hD0] = 32'd4; mem_b[8'hD1] = 32'd4;
        run_job(8'hC0, 8'hD0, 2, 65'd24, 1'b1, 0, 0, 1'b0);

        // randomized jobs
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 8; j++) begin
                mem_a[$urandom_range(0, 255)] = $urandom;
                mem_b[$urandom_range(0, 255)] = $urandom;
            end
            if (k == 10) len = 256;
            else if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 1);
            else len = $urandom_range(1, 24);
            stray = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (len == 0) ? 2 : len + 5) : 0;
            run_job($urandom_range(0, 255), $urandom_range(0, 255), len, 65'd0, 1'b0,
                    stray, 0, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("done_count", 128'(dones), 128'(exp_dones));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
